sram_bist_sched: RTL and testbench
==================================

Name: sram_bist_sched

Overview:
Top-level sequencer for the SRAM BIST engines in the AHB subsystem. On a start request it runs the enabled BIST engines one at a time, in index order, by driving each engine's test-enable. It handles each engine's done/fail handshake, applies a per-engine watchdog, and publishes pass/fail and timeout maps for a status register.

Parameters:
NUM_MEM, 4, number of BIST engines (SRAM instances) sequenced; legal range 1..16
IDX_W, 2, width of engine index; must equal ceil(log2(NUM_MEM)), minimum 1
TO_W, 18, watchdog counter width
TIMEOUT_CYCLES, 200000, maximum cycles an engine may run before it is declared hung; must be < 2**TO_W

Ports:
b_clk  in  1  BIST clock; all logic on the rising edge
b_rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse that starts a sweep; ignored while busy
mem_mask  in  NUM_MEM  engine enable; bit i=1 means test engine i; sampled at start
bist_te  out  NUM_MEM  per-engine test enable; registered, at most one bit high
bist_done  in  NUM_MEM  per-engine end pulse (one cycle)
bist_fail  in  NUM_MEM  per-engine result; valid in the cycle bist_done is high
busy  out  1  high from the cycle after start until the cycle done pulses
done  out  1  one-cycle pulse when the sweep completes
pass  out  1  1 when fail_map==0 and timeout_map==0; valid from done until the next start
fail_map  out  NUM_MEM  bit i set if engine i reported a fail
timeout_map  out  NUM_MEM  bit i set if engine i hit the watchdog
cur_idx  out  IDX_W  index of the engine currently under test

Behaviour:
- Reset values: bist_te=0, busy=0, done=0, pass=0, fail_map=0, timeout_map=0, cur_idx=0, state IDLE, watchdog=0.
- FSM states: IDLE, SEEK, RUN, RELEASE, FINISH.
- IDLE, start=1:
  - latch mem_mask into a mask register.
  - clear fail_map, timeout_map and pass.
  - set cur_idx=0, busy=1, go to SEEK.
- SEEK:
  - if mask[cur_idx]=1: set bist_te[cur_idx]=1, clear watchdog, go to RUN.
  - else if cur_idx==NUM_MEM-1: go to FINISH.
  - else: increment cur_idx and stay in SEEK.
  - each skipped engine costs one cycle.
- RUN: watchdog increments every cycle.
  - bist_done[cur_idx]=1: fail_map[cur_idx]<=bist_fail[cur_idx]; go to RELEASE.
  - else watchdog==TIMEOUT_CYCLES-1: timeout_map[cur_idx]<=1; go to RELEASE.
  - done has priority over timeout in the same cycle.
  - done/fail inputs of non-selected engines are ignored.
- RELEASE:
  - bist_te goes to 0 in the cycle after done is seen. This is mandatory: an engine restarts if enable is still high the cycle after its done pulse.
  - RELEASE lasts exactly one cycle.
  - then, if cur_idx==NUM_MEM-1, go to FINISH; else increment cur_idx and go to SEEK.
- FINISH:
  - done=1 for one cycle; pass<=(fail_map==0 && timeout_map==0).
  - busy=0 from the same cycle; return to IDLE.
- Empty mask: SEEK walks all indices, then done pulses with pass=1. Latency from start is NUM_MEM+2 cycles.
- start while busy: ignored, no effect on mask or maps.
- b_rst mid-sweep: all outputs return to reset values, bist_te drops immediately on that edge, no done pulse.
- Watchdog saturates (never wraps) while in RUN. Width arithmetic is unsigned, TO_W bits.
- cur_idx never exceeds NUM_MEM-1.

Optional Feature:
BIST_RETRY_EN
- Defined: an engine reporting fail or timeout is rerun once. RELEASE returns to SEEK with the same cur_idx and sets a retry flag. fail_map/timeout_map bits reflect only the second run. The retry flag clears on advancing to the next index.
- Not defined: single pass per engine, as in Behaviour.

Decomposition:
- Package sram_bist_pkg:
  - FSM state enum (IDLE, SEEK, RUN, RELEASE, FINISH) encoding constants.
  - default TIMEOUT_CYCLES constant.
  - a per-engine cycle estimate constant BIST_CYCLES_8KX8 = 21*8192 for bench use.
- One natural sub-module: sram_bist_watchdog. It is a loadable saturating TO_W counter with a clear input and a terminal-count output, instantiated once.

Test Plan:
- NUM_MEM=4, mask=4'b1111, all engines done after 100 cycles with fail=0 -> bist_te walks 0001, 0010, 0100, 1000; each drops the cycle after its done; done pulses once; pass=1; fail_map=0.
- mask=4'b1010, engine 3 reports fail=1 -> engines 0 and 2 never enabled; fail_map=4'b1000; pass=0; timeout_map=0.
- mask=4'b0001, TIMEOUT_CYCLES=50, engine never pulses done -> timeout_map=4'b0001 after 50 RUN cycles; bist_te clears; done pulses; pass=0.
- mask=0 -> done exactly NUM_MEM+2 cycles after start; pass=1; bist_te never set.
- start pulse during RUN, then b_rst mid-sweep -> second start ignored; after reset all outputs 0 and bist_te=0 on the next edge.
- BIST_RETRY_EN defined, engine 1 fails first run and passes second -> bist_te[1] asserted twice; fail_map=0; pass=1.

Source files
------------

// File: rtl/sram_bist_sched_pkg.sv
// sram_bist_pkg: shared FSM encoding and timing constants for the SRAM BIST sequencer
package sram_bist_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEEK    = 3'd1,
    RUN     = 3'd2,
    RELEASE = 3'd3,
    FINISH  = 3'd4
  } state_e;
  localparam int TIMEOUT_CYCLES_DEF = 200000;
  localparam int BIST_CYCLES_8KX8   = 21 * 8192;
endpackage

// File: rtl/sram_bist_sched_if.sv
// sram_bist_sched_if: host start/status and per-engine BIST handshake bundle
interface sram_bist_sched_if #(
  parameter int NUM_MEM = 4,
  parameter int IDX_W   = 2
);
  logic               start;
  logic [NUM_MEM-1:0] mem_mask;
  logic [NUM_MEM-1:0] bist_te;
  logic [NUM_MEM-1:0] bist_done;
  logic [NUM_MEM-1:0] bist_fail;
  logic               busy;
  logic               done;
  logic               pass;
  logic [NUM_MEM-1:0] fail_map;
  logic [NUM_MEM-1:0] timeout_map;
  logic [IDX_W-1:0]   cur_idx;
  modport master (
    input  start, mem_mask, bist_done, bist_fail,
    output bist_te, busy, done, pass, fail_map, timeout_map, cur_idx
  );
  modport slave (
    output start, mem_mask, bist_done, bist_fail,
    input  bist_te, busy, done, pass, fail_map, timeout_map, cur_idx
  );
endinterface

// File: rtl/sram_bist_sched_watchdog.sv
// sram_bist_watchdog: clearable saturating cycle counter flagging the hang threshold
module sram_bist_watchdog #(
  parameter int TO_W           = 18,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [TO_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign tc_o = cnt_q == TO_W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/sram_bist_sched.sv
// sram_bist_sched: runs enabled SRAM BIST engines in index order with per-engine watchdog
// Define BIST_RETRY_EN to rerun a failing or hung engine once before moving on.
module sram_bist_sched
  import sram_bist_pkg::*;
#(
  parameter int NUM_MEM        = 4,
  parameter int IDX_W          = 2,
  parameter int TO_W           = 18,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic b_clk,
  input logic b_rst,
  sram_bist_sched_if.master bus
);
  state_e             state_q, state_d;
  logic [NUM_MEM-1:0] mask_q, mask_d, te_q, te_d, fmap_q, fmap_d, tmap_q, tmap_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic               wd_tc, last;
`ifdef BIST_RETRY_EN
  logic               retry_q, retry_d;
`endif
  assign last = idx_q == IDX_W'(NUM_MEM - 1);
  sram_bist_watchdog #(.TO_W(TO_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk  (b_clk),
    .rst  (b_rst),
    .clr_i(state_q == SEEK),
    .en_i (state_q == RUN),
    .tc_o (wd_tc)
  );
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    te_d    = te_q;
    fmap_d  = fmap_q;
    tmap_d  = tmap_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
`ifdef BIST_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      IDLE: if (bus.start) begin
        mask_d  = bus.mem_mask;
        fmap_d  = '0;
        tmap_d  = '0;
        pass_d  = 1'b0;
        idx_d   = '0;
        busy_d  = 1'b1;
`ifdef BIST_RETRY_EN
        retry_d = 1'b0;
`endif
        state_d = SEEK;
      end
      SEEK: if (mask_q[idx_q]) begin
        te_d    = NUM_MEM'(1) << idx_q;
        state_d = RUN;
      end else begin
        state_d = last ? FINISH : SEEK;
        idx_d   = last ? idx_q : idx_q + 1'b1;
      end
      RUN: if (bus.bist_done[idx_q]) begin
        fmap_d[idx_q] = bus.bist_fail[idx_q];
        te_d          = '0;
        state_d       = RELEASE;
      end else if (wd_tc) begin
        tmap_d[idx_q] = 1'b1;
        te_d          = '0;
        state_d       = RELEASE;
      end
      RELEASE: begin
`ifdef BIST_RETRY_EN
        if (!retry_q && (fmap_q[idx_q] || tmap_q[idx_q])) begin
          retry_d       = 1'b1;
          fmap_d[idx_q] = 1'b0;
          tmap_d[idx_q] = 1'b0;
          state_d       = SEEK;
        end else begin
          retry_d = 1'b0;
          state_d = last ? FINISH : SEEK;
          idx_d   = last ? idx_q : idx_q + 1'b1;
        end
`else
        state_d = last ? FINISH : SEEK;
        idx_d   = last ? idx_q : idx_q + 1'b1;
`endif
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = ~|{fmap_q, tmap_q};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge b_clk) begin
    if (b_rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      te_q    <= '0;
      fmap_q  <= '0;
      tmap_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef BIST_RETRY_EN
      retry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      te_q    <= te_d;
      fmap_q  <= fmap_d;
      tmap_q  <= tmap_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef BIST_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end
  assign bus.bist_te     = te_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.fail_map    = fmap_q;
  assign bus.timeout_map = tmap_q;
  assign bus.cur_idx     = idx_q;
endmodule

// File: tb/tb_sram_bist_sched.sv
// tb_sram_bist_sched: directed sweeps against modelled BIST engines, scoreboard-checked on done
module tb_sram_bist_sched;
  localparam int N = 4;
  typedef struct {
    logic         pass;
    logic [N-1:0] fm;
    logic [N-1:0] tm;
    logic [63:0]  hist;
    int           lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, start_cyc = 0, done_seen = 0;
  int lat_cfg[N];
  int mode_cfg[N];
  sram_bist_sched_if #(.NUM_MEM(N), .IDX_W(2)) bus ();
  sram_bist_sched #(.NUM_MEM(N), .IDX_W(2), .TO_W(18), .TIMEOUT_CYCLES(50)) dut (
    .b_clk(clk),
    .b_rst(rst),
    .bus  (bus)
  );
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Engine model: done after lat_cfg cycles of enable (0 = hangs); mode 1 always fails, mode 2 fails first run only
  initial begin
    int cnt[N];
    int runs[N];
    logic [N-1:0] prev;
    cnt = '{default: 0};
    runs = '{default: 0};
    prev = '0;
    bus.bist_done = '0;
    bus.bist_fail = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.start) runs = '{default: 0};
      for (int i = 0; i < N; i++) begin
        if (bus.bist_te[i]) begin
          if (!prev[i]) begin
            runs[i]++;
            cnt[i] = 0;
          end
          cnt[i]++;
          bus.bist_done[i] = lat_cfg[i] != 0 && cnt[i] == lat_cfg[i];
          bus.bist_fail[i] = bus.bist_done[i] && (mode_cfg[i] == 1 || (mode_cfg[i] == 2 && runs[i] == 1));
        end else begin
          bus.bist_done[i] = 1'b0;
          bus.bist_fail[i] = 1'b0;
        end
      end
      prev = bus.bist_te;
    end
  end
  initial begin
    logic [63:0] hist;
    logic [N-1:0] tprev, dte;
    exp_t e;
    hist = '0;
    tprev = '0;
    dte = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hist = '0;
        tprev = '0;
        dte = '0;
      end else begin
        if (dte != 0) check("te_release", 64'(bus.bist_te & dte), 64'(0));
        dte = bus.bist_done & bus.bist_te;
        if (bus.bist_te != 0 && bus.bist_te != tprev) hist = {hist[59:0], bus.bist_te};
        tprev = bus.bist_te;
        if (bus.done) begin
          done_seen++;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected 0");
          end else begin
            e = q.pop_front();
            check("pass", 64'(bus.pass), 64'(e.pass));
            check("fail_map", 64'(bus.fail_map), 64'(e.fm));
            check("timeout_map", 64'(bus.timeout_map), 64'(e.tm));
            check("te_history", hist, e.hist);
            check("busy_at_done", 64'(bus.busy), 64'(0));
            check("te_at_done", 64'(bus.bist_te), 64'(0));
            check("cur_idx_at_done", 64'(bus.cur_idx), 64'(N - 1));
            if (e.lat >= 0) check("latency", 64'(cyc - start_cyc), 64'(e.lat));
          end
          hist = '0;
        end
      end
    end
  end
  task automatic sweep(input logic [N-1:0] m, input exp_t e, input int poke);
    int n;
    q.push_back(e);
    n = done_seen;
    @(negedge clk);
    bus.mem_mask = m;
    bus.start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mem_mask = '0;
    if (poke > 0) begin
      repeat (poke) @(negedge clk);
      bus.mem_mask = '1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.mem_mask = '0;
    end
    for (int k = 0; k < 3000 && done_seen == n; k++) @(posedge clk);
    checks++;
    if (done_seen == n) begin
      errors++;
      $display("FAIL sweep_timeout: got no done in 3000 cycles expected one");
      q.delete(q.size() - 1);
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_te"}, 64'(bus.bist_te), 64'(0));
    check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    check({tag, "_done"}, 64'(bus.done), 64'(0));
    check({tag, "_pass"}, 64'(bus.pass), 64'(0));
    check({tag, "_fail_map"}, 64'(bus.fail_map), 64'(0));
    check({tag, "_timeout_map"}, 64'(bus.timeout_map), 64'(0));
    check({tag, "_cur_idx"}, 64'(bus.cur_idx), 64'(0));
  endtask
  initial begin
    exp_t e;
    bus.start = 1'b0;
    bus.mem_mask = '0;
    lat_cfg = '{default: 20};
    mode_cfg = '{default: 0};
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    e = '{1'b1, 4'b0000, 4'b0000, 64'h1248, -1};
    sweep(4'b1111, e, 0);
    mode_cfg = '{0, 0, 0, 1};
`ifdef BIST_RETRY_EN
    e = '{1'b0, 4'b1000, 4'b0000, 64'h288, -1};
`else
    e = '{1'b0, 4'b1000, 4'b0000, 64'h28, -1};
`endif
    sweep(4'b1010, e, 0);
    mode_cfg = '{default: 0};
    lat_cfg = '{0, 20, 20, 20};
`ifdef BIST_RETRY_EN
    e = '{1'b0, 4'b0000, 4'b0001, 64'h11, -1};
`else
    e = '{1'b0, 4'b0000, 4'b0001, 64'h1, -1};
`endif
    sweep(4'b0001, e, 0);
    lat_cfg = '{default: 20};
    e = '{1'b1, 4'b0000, 4'b0000, 64'h0, N + 2};
    sweep(4'b0000, e, 0);
    mode_cfg = '{0, 2, 0, 0};
`ifdef BIST_RETRY_EN
    e = '{1'b1, 4'b0000, 4'b0000, 64'h22, -1};
`else
    e = '{1'b0, 4'b0010, 4'b0000, 64'h2, -1};
`endif
    sweep(4'b0010, e, 0);
    mode_cfg = '{default: 0};
    e = '{1'b1, 4'b0000, 4'b0000, 64'h12, -1};
    sweep(4'b0011, e, 10);
    @(negedge clk);
    bus.mem_mask = '1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mem_mask = '0;
    repeat (30) @(negedge clk);
    check("mid_sweep_busy", 64'(bus.busy), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("pending_expectations", 64'(q.size()), 64'(0));
    check("done_count", 64'(done_seen), 64'(6));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
